// File: rtl/inst_rom_loader.sv
// Instruction ROM loader: assembles a big-endian byte stream into 32-bit
// words and writes them to consecutive instruction ROM word addresses,
// holding the CPU core in reset while a load is in progress.
// Optional feature macro: LOADER_CHECKSUM_EN adds a 32-bit XOR checksum
// output (checksum_o) over all words written since the last start.
module inst_rom_loader #(
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH:0]   word_cnt_i,
    input  logic                  byte_valid_i,
    input  logic [7:0]            byte_data_i,
    output logic                  byte_ready_o,
    output logic                  rom_we_o,
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    output logic [31:0]           rom_data_o,
    output logic                  cpu_rst_o,
    output logic                  busy_o,
`ifdef LOADER_CHECKSUM_EN
    output logic [31:0]           checksum_o,
`endif
    output logic                  done_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH:0]   remaining;
    logic [1:0]            byte_idx;
    logic [31:0]           word;
    logic                  byte_accept;

    // Bytes are only taken while collecting; the write cycle stalls the stream.
    assign byte_ready_o = (state == COLLECT);
    assign byte_accept  = byte_valid_i & byte_ready_o;

    // The address counter and shift register drive the ROM port directly;
    // both hold their value through the single write cycle.
    assign rom_addr_o = addr;
    assign rom_data_o = word;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode: a zero-length request completes without writing.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start_i) begin
                    next_state = (word_cnt_i == '0) ? DONE : COLLECT;
                end
            end
            COLLECT: begin
                if (byte_accept && (byte_idx == 2'd3)) begin
                    next_state = WRITE;
                end
            end
            WRITE: begin
                next_state = (remaining == (ADDR_WIDTH+1)'(1)) ? DONE : COLLECT;
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Address, remaining count, byte index and word assembly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr      <= '0;
            remaining <= '0;
            byte_idx  <= 2'd0;
            word      <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i && (word_cnt_i != '0)) begin
                        addr      <= base_addr_i;
                        remaining <= word_cnt_i;
                        byte_idx  <= 2'd0;
                    end
                end
                COLLECT: begin
                    if (byte_accept) begin
                        word     <= {word[23:0], byte_data_i};
                        byte_idx <= (byte_idx == 2'd3) ? 2'd0 : byte_idx + 2'd1;
                    end
                end
                WRITE: begin
                    addr      <= addr + 1'b1;
                    remaining <= remaining - 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Registered status outputs, decoded from the state being entered so
    // they line up with that state's cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_we_o  <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            cpu_rst_o <= 1'b1;
        end else begin
            rom_we_o  <= (next_state == WRITE);
            busy_o    <= (next_state == COLLECT) || (next_state == WRITE);
            done_o    <= (next_state == DONE);
            cpu_rst_o <= (next_state != IDLE);
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running XOR of written words; restarts on every start request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum_o <= 32'd0;
        end else if ((state == IDLE) && start_i) begin
            checksum_o <= 32'd0;
        end else if (state == WRITE) begin
            checksum_o <= checksum_o ^ word;
        end
    end
`endif

endmodule

// File: tb/tb_inst_rom_loader.sv
// Self-checking bench for inst_rom_loader: drives loads with random stalls
// and compares ROM writes, completion timing and status against a simple
// reference computed from the load parameters. Covers LOADER_CHECKSUM_EN
// when that macro is defined.
module tb_inst_rom_loader;

    localparam int AW = 17;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] baseAddr;
    logic [AW:0]   wordCnt;
    logic          byteValid;
    logic [7:0]    byteData;
    logic          byteReady;
    logic          romWe;
    logic [AW-1:0] romAddr;
    logic [31:0]   romData;
    logic          cpuRst;
    logic          busy;
    logic          done;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]   checksum;
`endif

    inst_rom_loader #(.ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .base_addr_i  (baseAddr),
        .word_cnt_i   (wordCnt),
        .byte_valid_i (byteValid),
        .byte_data_i  (byteData),
        .byte_ready_o (byteReady),
        .rom_we_o     (romWe),
        .rom_addr_o   (romAddr),
        .rom_data_o   (romData),
        .cpu_rst_o    (cpuRst),
        .busy_o       (busy),
`ifdef LOADER_CHECKSUM_EN
        .checksum_o   (checksum),
`endif
        .done_o       (done)
    );

    always #5 clk = ~clk;

    int testsRun    = 0;
    int testsFailed = 0;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Observation of the ROM port and status lines, once per cycle.
    logic [AW+31:0] obsQ[$];
    int  cycle = 0;
    int  lastWeCycle = 0;
    int  doneCycle = 0;
    int  doneCount = 0;
    int  cpuRstBad = 0;
    int  readyBad = 0;
    int  readyHigh = 0;
    int  busyGap = 0;
    int  byteTimeouts = 0;
    bit  trackBusy = 1'b0;

    always @(negedge clk) begin
        cycle++;
        if (romWe) begin
            obsQ.push_back({romAddr, romData});
            lastWeCycle = cycle;
        end
        if (done) begin
            doneCount++;
            doneCycle = cycle;
        end
        if ((busy || done) && !cpuRst) cpuRstBad++;
        if (byteReady && (!busy || romWe)) readyBad++;
        if (byteReady) readyHigh++;
        if (trackBusy && !busy && !done) busyGap++;
    end

    // Present one byte after a number of idle cycles and hold it until taken.
    task automatic sendByte(input logic [7:0] b, input int stall);
        bit acc;
        int n;
        repeat (stall) begin
            @(posedge clk);
            #1;
        end
        byteValid = 1'b1;
        byteData  = b;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = byteReady;
            @(posedge clk);
            #1;
            n++;
        end
        byteValid = 1'b0;
        byteData  = $urandom;
        if (!acc) byteTimeouts++;
    endtask

    // Run one full load and compare against the expected write sequence.
    task automatic applyStimulus(input logic [AW-1:0] base, input int cnt,
                                 input logic [31:0] w[$], input int minStall, input int maxStall);
        int startCycle;
        int n;
        logic [AW+31:0] expEntry;
        logic [31:0] expSum;
        obsQ.delete();
        doneCount = 0;
        busyGap = 0;
        readyHigh = 0;
        cpuRstBad = 0;
        readyBad = 0;
        byteTimeouts = 0;
        baseAddr = base;
        wordCnt  = (AW+1)'(cnt);
        start    = 1'b1;
        @(posedge clk);
        startCycle = cycle;
        #1;
        start    = 1'b0;
        baseAddr = $urandom;
        wordCnt  = $urandom;
        trackBusy = 1'b1;
`ifdef LOADER_CHECKSUM_EN
        checkOutput("cksum_clear", 64'(checksum), 64'd0);
`endif
        expSum = 32'd0;
        for (int i = 0; i < cnt; i++) begin
            expSum = expSum ^ w[i];
            for (int b = 0; b < 4; b++) begin
                sendByte(w[i][31-8*b -: 8], int'($urandom_range(maxStall, minStall)));
            end
        end
        n = 0;
        while (doneCount == 0 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        trackBusy = 1'b0;
        checkOutput("done_seen", 64'(doneCount != 0), 64'd1);
        @(negedge clk);
        #1;
        checkOutput("done_pulses", 64'(doneCount), 64'd1);
        checkOutput("cpu_rst_idle", 64'(cpuRst), 64'd0);
        checkOutput("byte_timeout", 64'(byteTimeouts), 64'd0);
        checkOutput("wr_count", 64'(obsQ.size()), 64'(cnt));
        for (int i = 0; i < cnt && i < obsQ.size(); i++) begin
            expEntry = {AW'((int'(base) + i) % (1 << AW)), w[i]};
            checkOutput($sformatf("wr%0d", i), 64'(obsQ[i]), 64'(expEntry));
        end
        if (cnt > 0) begin
            checkOutput("done_lat", 64'(doneCycle), 64'(lastWeCycle + 1));
        end else begin
            checkOutput("done_lat0", 64'(doneCycle), 64'(startCycle + 1));
            checkOutput("ready_zero", 64'(readyHigh), 64'd0);
        end
        checkOutput("busy_gap", 64'(busyGap), 64'd0);
        checkOutput("cpu_rst_load", 64'(cpuRstBad), 64'd0);
        checkOutput("ready_state", 64'(readyBad), 64'd0);
`ifdef LOADER_CHECKSUM_EN
        checkOutput("cksum", 64'(checksum), 64'(expSum));
`endif
    endtask

    // Compare every output with its reset value.
    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_ready"}, 64'(byteReady), 64'd0);
        checkOutput({tag, "_we"}, 64'(romWe), 64'd0);
        checkOutput({tag, "_addr"}, 64'(romAddr), 64'd0);
        checkOutput({tag, "_data"}, 64'(romData), 64'd0);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
        checkOutput({tag, "_done"}, 64'(done), 64'd0);
        checkOutput({tag, "_cpurst"}, 64'(cpuRst), 64'd1);
`ifdef LOADER_CHECKSUM_EN
        checkOutput({tag, "_cksum"}, 64'(checksum), 64'd0);
`endif
    endtask

    initial begin
        logic [31:0] wq[$];
        int cnt;
        logic [AW-1:0] base;

        rst = 1'b1;
        start = 1'b0;
        baseAddr = '0;
        wordCnt = '0;
        byteValid = 1'b0;
        byteData = 8'd0;
        #12;
        checkResetOutputs("rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("cpu_rst_release", 64'(cpuRst), 64'd0);

        wq = '{32'h3C010101};
        applyStimulus(17'h00000, 1, wq, 0, 0);

        wq = '{32'h34210101, 32'h34221100, 32'h00221825};
        applyStimulus(17'h00010, 3, wq, 2, 2);

        wq = '{32'h11111111, 32'h22222222};
        applyStimulus(17'h1FFFF, 2, wq, 0, 1);

        wq.delete();
        applyStimulus(17'h00123, 0, wq, 0, 0);

        wq = '{32'h0F0F0F0F, 32'hFF00FF00};
        applyStimulus(17'h00040, 2, wq, 0, 1);

        // Abandon a four-word load two bytes into its second word.
        obsQ.delete();
        baseAddr = 17'h00005;
        wordCnt  = 18'd4;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        sendByte(8'h01, 0);
        sendByte(8'h02, 1);
        sendByte(8'h03, 0);
        sendByte(8'h04, 0);
        sendByte(8'h55, 0);
        sendByte(8'h66, 0);
        #2;
        rst = 1'b1;
        #1;
        checkResetOutputs("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("midrst_wr_count", 64'(obsQ.size()), 64'd1);
        if (obsQ.size() > 0) begin
            checkOutput("midrst_wr0", 64'(obsQ[0]), 64'({17'h00005, 32'h01020304}));
        end
        wq = '{32'hAABBCCDD};
        applyStimulus(17'h00077, 1, wq, 0, 2);

        for (int t = 0; t < 6; t++) begin
            cnt = int'($urandom_range(4, 1));
            base = (t % 2 == 0) ? AW'($urandom) : AW'((1 << AW) - int'($urandom_range(3, 1)));
            wq.delete();
            for (int i = 0; i < cnt; i++) wq.push_back($urandom);
            applyStimulus(base, cnt, wq, 0, 3);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/inst_rom_loader.md
Name: inst_rom_loader

Overview:
- Fills the instruction ROM write port from a byte stream so programs can be loaded at run time instead of by simulator preload.
- It is the writer side of the ROM that the fetch stage reads.
- Assembles big-endian bytes into 32-bit words and writes them to consecutive word addresses.
- Holds the CPU in reset while a load is in progress.

Parameters:
ADDR_WIDTH, 17, word-address width of the instruction ROM (131072 words)

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start_i  input  1  one-cycle load request; sampled only in IDLE
- base_addr_i  input  ADDR_WIDTH  first word address; latched on accepted start
- word_cnt_i  input  ADDR_WIDTH+1  number of words to load; latched on accepted start
- byte_valid_i  input  1  byte_data_i is valid
- byte_data_i  input  8  stream byte, MSB-first within each word
- byte_ready_o  output  1  loader accepts a byte this cycle
- rom_we_o  output  1  ROM write strobe
- rom_addr_o  output  ADDR_WIDTH  ROM word address
- rom_data_o  output  32  ROM write data
- cpu_rst_o  output  1  reset to the CPU core
- busy_o  output  1  load in progress
- done_o  output  1  one-cycle completion pulse

Behaviour:
- **Reset.** rst asynchronously forces:
  - state=IDLE; byte_ready_o=0, rom_we_o=0, rom_addr_o=0, rom_data_o=0;
  - busy_o=0, done_o=0, cpu_rst_o=1 while rst is high;
  - byte index=0, remaining count=0.
- **Registers.** All outputs are registered except byte_ready_o, which is decoded from state (1 only in COLLECT). cpu_rst_o = 1 in COLLECT, WRITE and DONE, else 0.
- **IDLE.**
  - start_i=1 with word_cnt_i!=0: latch base_addr_i into the address counter and word_cnt_i into the remaining counter, clear byte index, go to COLLECT.
  - start_i=1 with word_cnt_i==0: go to DONE without writing.
  - start_i outside IDLE is ignored.
- **COLLECT.**
  - A byte is accepted when byte_valid_i & byte_ready_o; the shift register does word = {word[23:0], byte}.
  - On the 4th accepted byte (index 3): go to WRITE and reset the index to 0.
  - Bytes with valid low are not counted; arbitrary stalls are allowed.
- **WRITE (exactly one cycle).**
  - rom_we_o=1, rom_addr_o=current address, rom_data_o=assembled word; byte_ready_o=0.
  - Address increments modulo 2^ADDR_WIDTH; remaining decrements.
  - If remaining was 1: go to DONE, else back to COLLECT.
- **Latency.** The 4th byte accepted at edge N gives rom_we_o high in the cycle after edge N. The minimum is 5 cycles per word.
- **DONE (one cycle).** done_o=1, busy_o=0, then IDLE; cpu_rst_o drops on entering IDLE.
- busy_o=1 in COLLECT and WRITE.
- **Wrap-around.** An address of 2^ADDR_WIDTH-1 followed by a further word writes address 0 next. No error is flagged.
- **Maximum count.** word_cnt_i=2^ADDR_WIDTH is a legal full-ROM load.
- **Reset mid-load.** Abandons the load immediately: no further writes, partial word discarded, the next start begins fresh.

Optional Feature:
LOADER_CHECKSUM_EN
- Defined:
  - Adds output checksum_o (32). It is cleared to 0 on reset and on an accepted start.
  - It is XORed with each word at its WRITE cycle (checksum_o updates at the end of the WRITE cycle) and holds its value after DONE until the next start.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
1. **Single word.** Reset, then start base=0x00000, cnt=1, bytes 3C 01 01 01 with no stalls.
   - rom_we_o pulses once with addr 0, data 0x3C010101.
   - done_o pulses the next cycle; cpu_rst_o is 1 from the cycle after start until done_o.
2. **Multi-word with stalls.** cnt=3, base=0x00010, byte_valid_i low for 2 cycles between every byte; words 34210101, 34221100, 00221825.
   - Writes go to addresses 0x10, 0x11, 0x12 in order; bytes are never dropped or duplicated.
   - busy_o is high throughout.
3. **Wrap-around.** base=0x1FFFF, cnt=2, words 11111111, 22222222 → writes to 0x1FFFF then 0x00000.
4. **Zero count.** start with cnt=0 → no rom_we_o, done_o=1 one cycle later, byte_ready_o stays 0.
5. **Reset mid-load.** Assert rst after 2 bytes of word 2 in a cnt=4 load.
   - Outputs return to reset values asynchronously; word 1's write is the only one that occurred.
   - A subsequent start with cnt=1, bytes AA BB CC DD writes 0xAABBCCDD with no stale bytes.
6. **Checksum** (LOADER_CHECKSUM_EN). Words 0x0F0F0F0F and 0xFF00FF00 → checksum_o=0xF00FF00F after DONE. A new start clears it to 0.
